adc_frame_receiver: RTL and testbench

Deserialises the external audio-band ADC's serial TDM stream (bit clock, frame sync, data) into one signed parallel sample per frame, plus a single-cycle strobe. It sits directly upstream of `down_conversion_sys`: `out` drives that block's `in` and `valid` drives its `en`, which is the 512 ksps sample strobe. All ADC pins are oversampled in the system clock domain; no ADC-derived clock is used as a clock.

---
 rtl/adc_frame_receiver.sv | 183 ++++++++++++++++++
 tb/tb_adc_frame_receiver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_receiver.sv
// adc_frame_receiver
// Deserialises an oversampled TDM ADC stream (bit clock, frame sync, data)
// into one signed parallel sample per frame plus a single-cycle strobe.
// All ADC pins are synchronised into clk; the ADC bit clock is never used
// as a clock.
// Optional build macro: ADC_FRAME_CHECK_EN enables the frame_err pulse on
// early-sync and missing-sync events; when undefined frame_err is tied low.
module adc_frame_receiver #(
    parameter int DW   = 24,
    parameter int FW   = 64,
    parameter int SLOT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adc_sclk,
    input  logic                 adc_fs,
    input  logic                 adc_sdata,
    output logic signed [DW-1:0] out,
    output logic                 valid,
    output logic                 frame_err
);

    localparam int            BW      = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [BW-1:0] B_LAST  = BW'(FW - 1);
    localparam logic [BW-1:0] SLOT_LO = BW'(SLOT * DW);
    localparam logic [BW-1:0] SLOT_HI = BW'(SLOT * DW + DW - 1);
    localparam logic [BW:0]   DW_EXT  = (BW+1)'(DW);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Synchroniser chains; sclk gets a third stage for rise detection.
    logic [2:0]    sclk_sync_q;
    logic [1:0]    fs_sync_q;
    logic [1:0]    sd_sync_q;

    state_e        state_q;
    logic [BW-1:0] b_q;
    logic [DW-1:0] shift_q;

    logic          tick_s;
    logic          fs_s;
    logic          sd_s;
    logic          at_last_s;
    logic          restart_s;
    logic          advance_s;
    logic          missing_s;
    logic [BW-1:0] new_b_s;
    logic [BW-1:0] rel_b_s;
    logic          in_slot_s;
    logic          capture_s;
    logic          word_done_s;
    logic [DW-1:0] shift_next_s;

    // Bring the three asynchronous ADC pins into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            fs_sync_q   <= 2'b00;
            sd_sync_q   <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], adc_sclk};
            fs_sync_q   <= {fs_sync_q[0], adc_fs};
            sd_sync_q   <= {sd_sync_q[0], adc_sdata};
        end
    end

    assign tick_s    = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign fs_s      = fs_sync_q[1];
    assign sd_s      = sd_sync_q[1];
    assign at_last_s = (b_q == B_LAST);

    // Classify each sclk rise: frame (re)start, ordinary advance, or missing sync.
    always_comb begin
        restart_s = 1'b0;
        advance_s = 1'b0;
        missing_s = 1'b0;
        if (tick_s) begin
            if (fs_s) begin
                restart_s = 1'b1;
            end else if (state_q == ST_RUN) begin
                if (at_last_s) begin
                    missing_s = 1'b1;
                end else begin
                    advance_s = 1'b1;
                end
            end else begin
                advance_s = 1'b0;
            end
        end else begin
            restart_s = 1'b0;
        end
    end

    // Bit index after this tick and whether that bit belongs to the captured slot.
    // A wrapped (negative) offset lands above DW, so bits before the slot are rejected.
    always_comb begin
        if (restart_s) begin
            new_b_s = '0;
        end else begin
            new_b_s = b_q + BW'(1);
        end
        rel_b_s      = new_b_s - SLOT_LO;
        in_slot_s    = ({1'b0, rel_b_s} < DW_EXT);
        capture_s    = (restart_s | advance_s) & in_slot_s;
        word_done_s  = capture_s & (new_b_s == SLOT_HI);
        shift_next_s = {shift_q[DW-2:0], sd_s};
    end

    // Frame FSM, bit counter, slot shift register and registered sample outputs.
    // Restarting the counter at 0 on early sync means a truncated slot can never
    // reach SLOT_HI, so it is discarded without an extra flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            b_q     <= '0;
            shift_q <= '0;
            out     <= '0;
            valid   <= 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (restart_s) begin
                        state_q <= ST_RUN;
                        b_q     <= '0;
                    end else begin
                        state_q <= ST_HUNT;
                        b_q     <= '0;
                    end
                end
                ST_RUN: begin
                    if (missing_s) begin
                        state_q <= ST_HUNT;
                        b_q     <= '0;
                    end else if (restart_s | advance_s) begin
                        state_q <= ST_RUN;
                        b_q     <= new_b_s;
                    end else begin
                        state_q <= ST_RUN;
                        b_q     <= b_q;
                    end
                end
                default: begin
                    state_q <= ST_HUNT;
                    b_q     <= '0;
                end
            endcase

            if (capture_s) begin
                shift_q <= shift_next_s;
            end else begin
                shift_q <= shift_q;
            end

            if (word_done_s) begin
                out   <= $signed(shift_next_s);
                valid <= 1'b1;
            end else begin
                out   <= out;
                valid <= 1'b0;
            end
        end
    end

`ifdef ADC_FRAME_CHECK_EN
    logic early_s;
    assign early_s = restart_s & (state_q == ST_RUN) & ~at_last_s;

    // One-cycle framing error pulse, registered on the same edge as the FSM update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= early_s | missing_s;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_frame_receiver.sv
// Testbench for adc_frame_receiver: a SLOT=0 and a SLOT=1 instance share one
// serial stream. Frame windows are driven from a vector table; reset mid-frame
// and a jittered ramp are hand-written sequences.
module tb_adc_frame_receiver;

    localparam int DW = 24;
    localparam int FW = 64;
`ifdef ADC_FRAME_CHECK_EN
    localparam int EW = 1;
`else
    localparam int EW = 0;
`endif

    typedef struct {
        int          len;
        logic        fs;
        logic [23:0] s0;
        logic [23:0] s1;
        int          v0;
        logic [23:0] o0;
        int          v1;
        logic [23:0] o1;
        int          e;
        logic        probe;
    } vec_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b1;
    logic adc_sclk  = 1'b0;
    logic adc_fs    = 1'b0;
    logic adc_sdata = 1'b0;

    logic signed [DW-1:0] out0;
    logic signed [DW-1:0] out1;
    logic valid0, valid1, err0, err1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int v0_cnt = 0;
    int v1_cnt = 0;
    int e0_cnt = 0;
    int e1_cnt = 0;

    vec_t vecs[8];

    always #5 clk = ~clk;

    adc_frame_receiver #(.DW(DW), .FW(FW), .SLOT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .adc_sclk(adc_sclk), .adc_fs(adc_fs),
        .adc_sdata(adc_sdata), .out(out0), .valid(valid0), .frame_err(err0)
    );

    adc_frame_receiver #(.DW(DW), .FW(FW), .SLOT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .adc_sclk(adc_sclk), .adc_fs(adc_fs),
        .adc_sdata(adc_sdata), .out(out1), .valid(valid1), .frame_err(err1)
    );

    // Count strobe and error pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid0) v0_cnt++;
        if (valid1) v1_cnt++;
        if (err0)   e0_cnt++;
        if (err1)   e1_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One bit: data/fs change with sclk low, sclk high for hi clk periods.
    task automatic send_bit(input logic fs, input logic sd, input logic probe,
                            input int lo, input int hi);
        adc_sclk  = 1'b0;
        adc_fs    = fs;
        adc_sdata = sd;
        repeat (lo) @(negedge clk);
        adc_sclk = 1'b1;
        for (int j = 0; j < hi; j++) begin
            @(posedge clk);
            #1;
            if (probe && j == 1) check("latency edge k+1 valid", {31'd0, valid0}, 32'd0);
            if (probe && j == 2) check("latency edge k+2 valid", {31'd0, valid0}, 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [FW-1:0] fr, input int len, input logic fs_on,
                              input logic probe, input logic jit);
        int lo;
        int hi;
        for (int i = 0; i < len; i++) begin
            lo = jit ? 3 + int'($urandom_range(2, 0)) : 4;
            hi = jit ? 3 + int'($urandom_range(2, 0)) : 4;
            send_bit(fs_on && (i == 0), fr[FW-1-i], probe && (i == DW-1), lo, hi);
        end
    endtask

    initial begin
        int sv0, sv1, se0, se1;
        logic [FW-1:0] fr;
        logic [23:0]   rs0;

        //            len fs   s0          s1          v0 o0          v1 o1          e  probe
        vecs[0] = '{64, 1'b1, 24'h400000, 24'h123456, 1, 24'h400000, 1, 24'h123456, 0, 1'b0};
        vecs[1] = '{64, 1'b1, 24'hC00000, 24'hABCDEF, 1, 24'hC00000, 1, 24'hABCDEF, 0, 1'b1};
        vecs[2] = '{30, 1'b1, 24'h111111, 24'h222222, 1, 24'h111111, 0, 24'hABCDEF, 0, 1'b0};
        vecs[3] = '{10, 1'b1, 24'h333333, 24'h444444, 0, 24'h111111, 0, 24'hABCDEF, 1, 1'b0};
        vecs[4] = '{64, 1'b1, 24'h5A5A5A, 24'hA5A5A5, 1, 24'h5A5A5A, 1, 24'hA5A5A5, 1, 1'b0};
        vecs[5] = '{64, 1'b0, 24'h0F0F0F, 24'hF0F0F0, 0, 24'h5A5A5A, 0, 24'hA5A5A5, 1, 1'b0};
        vecs[6] = '{64, 1'b1, 24'h654321, 24'h0FEDCB, 1, 24'h654321, 1, 24'h0FEDCB, 0, 1'b0};
        vecs[7] = '{64, 1'b1, 24'h800000, 24'h7FFFFF, 1, 24'h800000, 1, 24'h7FFFFF, 0, 1'b0};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out0",   {8'h00, out0}, 32'h0);
        check("reset valid0", {31'd0, valid0}, 32'd0);
        check("reset err0",   {31'd0, err0}, 32'd0);
        check("reset out1",   {8'h00, out1}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            sv0 = v0_cnt; sv1 = v1_cnt; se0 = e0_cnt; se1 = e1_cnt;
            send_frame({vecs[r].s0, vecs[r].s1, 16'hA5C3}, vecs[r].len, vecs[r].fs,
                       vecs[r].probe, 1'b0);
            check($sformatf("row%0d valid0 count", r), 32'(v0_cnt - sv0), 32'(vecs[r].v0));
            check($sformatf("row%0d out0", r), {8'h00, out0}, {8'h00, vecs[r].o0});
            check($sformatf("row%0d valid1 count", r), 32'(v1_cnt - sv1), 32'(vecs[r].v1));
            check($sformatf("row%0d out1", r), {8'h00, out1}, {8'h00, vecs[r].o1});
            check($sformatf("row%0d err0 count", r), 32'(e0_cnt - se0), 32'(vecs[r].e * EW));
            check($sformatf("row%0d err1 count", r), 32'(e1_cnt - se1), 32'(vecs[r].e * EW));
        end

        // Reset asserted at frame bit 12 of a frame carrying 0x7FFFFF.
        fr = {24'h7FFFFF, 24'h7FFFFF, 16'hA5C3};
        send_frame(fr, 12, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset out0",   {8'h00, out0}, 32'h0);
        check("midreset valid0", {31'd0, valid0}, 32'd0);
        check("midreset out1",   {8'h00, out1}, 32'h0);
        check("midreset err0",   {31'd0, err0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sv0 = v0_cnt; sv1 = v1_cnt; se0 = e0_cnt;
        for (int i = 12; i < FW; i++) begin
            send_bit(1'b0, fr[FW-1-i], 1'b0, 4, 4);
        end
        check("post-reset partial valid0", 32'(v0_cnt - sv0), 32'd0);
        check("post-reset partial valid1", 32'(v1_cnt - sv1), 32'd0);
        check("post-reset partial out0", {8'h00, out0}, 32'h0);
        sv0 = v0_cnt; sv1 = v1_cnt;
        send_frame(fr, FW, 1'b1, 1'b0, 1'b0);
        check("post-reset frame valid0", 32'(v0_cnt - sv0), 32'd1);
        check("post-reset frame out0", {8'h00, out0}, 32'h007FFFFF);
        check("post-reset frame out1", {8'h00, out1}, 32'h007FFFFF);
        check("post-reset err0", 32'(e0_cnt - se0), 32'd0);

        // Continuous ramp with +-1 clk sclk phase jitter.
        sv0 = v0_cnt; sv1 = v1_cnt; se0 = e0_cnt; se1 = e1_cnt;
        for (int f = 0; f < 80; f++) begin
            rs0 = 24'(f * 32'h0002A5F3 + 32'h00000101);
            send_frame({rs0, ~rs0, 16'h5A3C}, FW, 1'b1, 1'b0, 1'b1);
            check($sformatf("ramp%0d out0", f), {8'h00, out0}, {8'h00, rs0});
            check($sformatf("ramp%0d out1", f), {8'h00, out1}, {8'h00, ~rs0});
        end
        check("ramp valid0 total", 32'(v0_cnt - sv0), 32'd80);
        check("ramp valid1 total", 32'(v1_cnt - sv1), 32'd80);
        check("ramp err0 total",   32'(e0_cnt - se0), 32'd0);
        check("ramp err1 total",   32'(e1_cnt - se1), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
